ram16k_arbiter: RTL and testbench

Two-port requester arbiter in front of the `ram16k` single-port synchronous RAM (16384 x 16, one-cycle registered read). Port 0 is the CPU data port and port 1 the DMA/loader port. The block grants at most one access per cycle and drives the RAM's address, write-data and write-enable lines. It returns read data with a registered response strobe aligned to the RAM's one-cycle read latency, and supports a lock so one requester can own the RAM for a multi-access sequence.

---
 rtl/ram16k_arbiter_if.sv | 51 +++++
 rtl/ram16k_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram16k_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram16k_arbiter_if.sv
// ram16k_arbiter_if
// Bundles the two requester handshakes, the two read-response channels and
// the RAM-side drive/return lines of the ram16k arbiter.
//   slave  : arbiter view (requests and mem_data_out in; ready, responses,
//            mem_addr/mem_data_in/mem_we out)
//   master : requester/RAM view (mirror image of slave)
interface ram16k_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_we;
    logic              req0_lock;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic              req1_lock;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  mem_data_out,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_data_in, mem_we
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output mem_data_out,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_data_in, mem_we
    );
endinterface

// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter
// Two-port arbiter in front of the ram16k single-port RAM (one-cycle
// registered read). Port 0 is the CPU data port, port 1 the DMA/loader port.
// At most one access is granted per cycle; a requester may hold the RAM
// across several accesses with its lock bit.
//
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : asynchronous, active-high
//   bus    : ram16k_arbiter_if.slave (requests, ready, read responses,
//            RAM address/data/we drive and RAM read data return)
//
// Build option:
//   ARB_RR_EN defined   : round-robin on an IDLE conflict (port != rr_last wins)
//   ARB_RR_EN undefined : fixed priority, port 0 wins an IDLE conflict
//
// state | meaning
// IDLE  | no owner, grant by arbitration
// LOCK0 | port 0 owns the RAM, port 1 held off
// LOCK1 | port 1 owns the RAM, port 0 held off
module ram16k_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    ram16k_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
`ifdef ARB_RR_EN
    logic              rr_last_q;
`endif

    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_d;

    // Grant is combinational; held at zero during reset so nothing reaches
    // the RAM while the system is being reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ARB_RR_EN
                        gnt0 = rr_last_q;
                        gnt1 = !rr_last_q;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = bus.req0_valid;
                        gnt1 = bus.req1_valid;
                    end
                end
                LOCK0:   gnt0 = bus.req0_valid;
                LOCK1:   gnt1 = bus.req1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        if (gnt0) begin
            addr_d  = bus.req0_addr;
            wdata_d = bus.req0_wdata;
            we_d    = bus.req0_we;
        end else if (gnt1) begin
            addr_d  = bus.req1_addr;
            wdata_d = bus.req1_wdata;
            we_d    = bus.req1_we;
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.mem_addr    = addr_d;
    assign bus.mem_data_in = wdata_d;
    assign bus.mem_we      = we_d;

    // RAM read data is only forwarded to the port whose response is due.
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp0_rdata  = rsp0_valid_q ? bus.mem_data_out : '0;
    assign bus.rsp1_rdata  = rsp1_valid_q ? bus.mem_data_out : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ARB_RR_EN
            rr_last_q    <= 1'b1;
`endif
        end else begin
            rsp0_valid_q <= gnt0 && !bus.req0_we;
            rsp1_valid_q <= gnt1 && !bus.req1_we;
`ifdef ARB_RR_EN
            if (gnt0) begin
                rr_last_q <= 1'b0;
            end else if (gnt1) begin
                rr_last_q <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (gnt0 && bus.req0_lock) begin
                        state_q <= LOCK0;
                    end else if (gnt1 && bus.req1_lock) begin
                        state_q <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (gnt0 && !bus.req0_lock) begin
                        state_q <= IDLE;
                    end
                end
                LOCK1: begin
                    if (gnt1 && !bus.req1_lock) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb_ram16k_arbiter
// Drives both requester ports, models the ram16k RAM, and compares every
// cycle against a reference model of the arbitration rules.
module tb_ram16k_arbiter;

    logic clk;
    logic reset;

    ram16k_arbiter_if #(.ADDR_W(14), .DATA_W(16)) bus ();

    ram16k_arbiter #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // requester stimulus
    bit          pv    [2];
    bit          pwe   [2];
    bit          plock [2];
    logic [13:0] paddr [2];
    logic [15:0] pwd   [2];
    bit          acc   [2];

    assign bus.req0_valid = pv[0];
    assign bus.req0_we    = pwe[0];
    assign bus.req0_lock  = plock[0];
    assign bus.req0_addr  = paddr[0];
    assign bus.req0_wdata = pwd[0];
    assign bus.req1_valid = pv[1];
    assign bus.req1_we    = pwe[1];
    assign bus.req1_lock  = plock[1];
    assign bus.req1_addr  = paddr[1];
    assign bus.req1_wdata = pwd[1];

    // RAM model: one-cycle registered read, contents survive reset
    logic [15:0] ram [16384];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data_in;
        bus.mem_data_out <= ram[bus.mem_addr];
    end

    // reference model
    logic [15:0] shadow [16384];
    int          owner;      // -1 = nobody holds the lock
    int          last;       // port of most recent accepted transfer
    bit          exp_v0, exp_v1;
    logic [15:0] exp_d0, exp_d1;
    int          we_cnt;

    int errors;
    int checks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic exp_grant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (owner == 0) g0 = pv[0];
        else if (owner == 1) g1 = pv[1];
        else if (pv[0] && pv[1]) begin
`ifdef ARB_RR_EN
            if (last == 0) g1 = 1'b1;
            else g0 = 1'b1;
`else
            g0 = 1'b1;
`endif
        end else begin
            g0 = pv[0];
            g1 = pv[1];
        end
    endtask

    task automatic cycle();
        bit g0, g1, ew;
        logic [13:0] ea;
        logic [15:0] ed;
        @(negedge clk);
        exp_grant(g0, g1);
        ew = 1'b0; ea = '0; ed = '0;
        if (g0) begin ea = paddr[0]; ed = pwd[0]; ew = pwe[0]; end
        else if (g1) begin ea = paddr[1]; ed = pwd[1]; ew = pwe[1]; end
        chk("ready0", bus.req0_ready, g0);
        chk("ready1", bus.req1_ready, g1);
        chk("mem_we", bus.mem_we, ew);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_data_in", bus.mem_data_in, (g0 || g1) ? ed : 16'h0);
        chk("rsp0_valid", bus.rsp0_valid, exp_v0);
        chk("rsp0_rdata", bus.rsp0_rdata, exp_v0 ? exp_d0 : 16'h0);
        chk("rsp1_valid", bus.rsp1_valid, exp_v1);
        chk("rsp1_rdata", bus.rsp1_rdata, exp_v1 ? exp_d1 : 16'h0);
        if (ew) we_cnt++;
        @(posedge clk);
        acc[0] = g0;
        acc[1] = g1;
        exp_v0 = g0 && !pwe[0];
        exp_v1 = g1 && !pwe[1];
        if (exp_v0) exp_d0 = shadow[paddr[0]];
        if (exp_v1) exp_d1 = shadow[paddr[1]];
        if (ew) shadow[ea] = ed;
        if (g0) begin owner = plock[0] ? 0 : -1; last = 0; end
        if (g1) begin owner = plock[1] ? 1 : -1; last = 1; end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        owner  = -1;
        last   = 1;
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
        @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 1'b0);
        chk("rst_ready1", bus.req1_ready, 1'b0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_rsp0_rdata", bus.rsp0_rdata, 16'h0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 14'h0);
        chk("rst_mem_data_in", bus.mem_data_in, 16'h0);
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
    endtask

    task automatic set_req(input int p, input bit v, input bit we, input bit lk,
                           input logic [13:0] a, input logic [15:0] d);
        pv[p]    = v;
        pwe[p]   = we;
        plock[p] = lk;
        paddr[p] = a;
        pwd[p]   = d;
    endtask

    // a waiting request stays stable until it is accepted
    task automatic rand_req(input int p);
        if (pv[p] && !acc[p]) return;
        pv[p]    = ($urandom_range(0, 3) != 0);
        pwe[p]   = ($urandom_range(0, 2) == 0);
        plock[p] = ($urandom_range(0, 3) == 0);
        paddr[p] = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7));
        pwd[p]   = 16'($urandom);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        we_cnt = 0;
        reset  = 1'b1;
        for (int i = 0; i < 16384; i++) begin
            ram[i]    = 16'(i) ^ 16'h5A5A;
            shadow[i] = 16'(i) ^ 16'h5A5A;
        end
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        exp_d0 = '0;
        exp_d1 = '0;
        do_reset(2);

        // write then read back on port 0
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h0010, 16'hBEEF); cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h0010, 16'h0);    cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);       cycle();
        cycle();

        // both ports reading continuously
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h0001, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h0002, 16'h0);
        repeat (8) cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        cycle();

        // port 1 locked sequence with port 0 waiting
        set_req(1, 1'b1, 1'b1, 1'b1, 14'h0020, 16'h1100); cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h0005, 16'h0);
        for (int i = 1; i < 4; i++) begin
            set_req(1, 1'b1, (i != 2), 1'b1, 14'(32 + i), 16'(16'h1100 + i));
            cycle();
        end
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h0020, 16'h0);   cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);      cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);      cycle();

        // write on port 0, read same address on port 1 next cycle
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h3FFF, 16'h1234); cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h3FFF, 16'h0);    cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);       cycle();
        cycle();

        // reset with a response pending, then reset while LOCK0
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h0001, 16'h0);    cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        do_reset(1);
        cycle();
        set_req(0, 1'b1, 1'b0, 1'b1, 14'h0002, 16'h0);    cycle();
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);       cycle();
        do_reset(2);
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h0003, 16'h0);    cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);       cycle();

        // write-only traffic
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 1'b1, 1'b0, 14'(i), 16'hA5A5);
            cycle();
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        cycle();
        cycle();
        chk("we_cycles", 32'(we_cnt), 32'd4);

        // randomized traffic with an occasional reset
        for (int n = 0; n < 3000; n++) begin
            rand_req(0);
            rand_req(1);
            if (n == 1500) do_reset(1);
            else cycle();
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
